// File: rtl/triloc_seq_ctrl_if.sv
// Bundle of the anchor-input, shared-vertex, median and result handshake signals.
// master = sequencer side, slave = environment (source, vertex unit, median, sink).
interface triloc_seq_ctrl_if #(
   parameter int N = 8
);
   logic                in_valid;
   logic                in_ready;
   logic signed [N-1:0] xA, yA, xB, yB, xC, yC;
   logic signed [N:0]   rA, rB, rC;

   logic [1:0]          vtx_sel;
   logic signed [N-1:0] v_xU, v_yU, v_xV, v_yV, v_xW, v_yW;
   logic signed [N:0]   v_rU, v_rV, v_rW;
   logic signed [N+1:0] v_xT, v_yT;

   logic signed [N+1:0] m_xD, m_yD, m_xE, m_yE, m_xF, m_yF;
   logic signed [N+3:0] m_xM, m_yM;

   logic                out_valid;
   logic                out_ready;
   logic signed [N+3:0] xM, yM;
   logic                busy;

   modport master (
      input  in_valid, xA, yA, xB, yB, xC, yC, rA, rB, rC,
      output in_ready,
      output vtx_sel, v_xU, v_yU, v_xV, v_yV, v_xW, v_yW, v_rU, v_rV, v_rW,
      input  v_xT, v_yT,
      output m_xD, m_yD, m_xE, m_yE, m_xF, m_yF,
      input  m_xM, m_yM,
      output out_valid, xM, yM, busy,
      input  out_ready
   );

   modport slave (
      output in_valid, xA, yA, xB, yB, xC, yC, rA, rB, rC,
      input  in_ready,
      input  vtx_sel, v_xU, v_yU, v_xV, v_yV, v_xW, v_yW, v_rU, v_rV, v_rW,
      output v_xT, v_yT,
      input  m_xD, m_yD, m_xE, m_yE, m_xF, m_yF,
      output m_xM, m_yM,
      input  out_valid, xM, yM, busy,
      output out_ready
   );
endinterface

// File: rtl/triloc_seq_ctrl.sv
// Trilateration sequencer: time-shares one vertex unit over the D/E/F rotations,
// registers the three vertices for the median stage and holds the result on a valid/ready output.
module triloc_seq_ctrl #(
   parameter int N       = 8,
   parameter int VTX_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   triloc_seq_ctrl_if.master        bus
);

   if (VTX_LAT < 1 || VTX_LAT > 15) begin : g_bad_lat
      $error("triloc_seq_ctrl: VTX_LAT must be in 1..15");
   end

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_VD   = 3'd1;
   localparam logic [2:0] S_VE   = 3'd2;
   localparam logic [2:0] S_VF   = 3'd3;
   localparam logic [2:0] S_MED  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [3:0] CNT_LAST = 4'(VTX_LAT - 1);

   logic [2:0]          r_state;
   logic [3:0]          r_cnt;
   logic signed [N-1:0] r_xA, r_yA, r_xB, r_yB, r_xC, r_yC;
   logic signed [N:0]   r_rA, r_rB, r_rC;
   logic signed [N+1:0] r_xD, r_yD, r_xE, r_yE, r_xF, r_yF;
   logic signed [N+3:0] r_xM, r_yM;
   logic                w_last;

   assign w_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_xA <= '0; r_yA <= '0; r_xB <= '0; r_yB <= '0; r_xC <= '0; r_yC <= '0;
         r_rA <= '0; r_rB <= '0; r_rC <= '0;
         r_xD <= '0; r_yD <= '0; r_xE <= '0; r_yE <= '0; r_xF <= '0; r_yF <= '0;
         r_xM <= '0; r_yM <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_xA <= bus.xA; r_yA <= bus.yA;
                  r_xB <= bus.xB; r_yB <= bus.yB;
                  r_xC <= bus.xC; r_yC <= bus.yC;
                  r_rA <= bus.rA; r_rB <= bus.rB; r_rC <= bus.rC;
                  r_cnt   <= '0;
                  r_state <= S_VD;
               end
            end
            S_VD, S_VE, S_VF: begin
               if (w_last) begin
                  r_cnt <= '0;
                  case (r_state)
                     S_VD: begin
                        r_xD <= bus.v_xT; r_yD <= bus.v_yT; r_state <= S_VE;
                     end
                     S_VE: begin
                        r_xE <= bus.v_xT; r_yE <= bus.v_yT; r_state <= S_VF;
                     end
                     default: begin
                        r_xF <= bus.v_xT; r_yF <= bus.v_yT; r_state <= S_MED;
                     end
                  endcase
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_MED: begin
               r_xM    <= bus.m_xM;
               r_yM    <= bus.m_yM;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operands are a pure function of state and anchor registers, so they hold for the whole slot.
   always_comb begin
      bus.vtx_sel = 2'd3;
      bus.v_xU = '0; bus.v_yU = '0; bus.v_rU = '0;
      bus.v_xV = '0; bus.v_yV = '0; bus.v_rV = '0;
      bus.v_xW = '0; bus.v_yW = '0; bus.v_rW = '0;
      case (r_state)
         S_VD: begin
            bus.vtx_sel = 2'd0;
            bus.v_xU = r_xB; bus.v_yU = r_yB; bus.v_rU = r_rB;
            bus.v_xV = r_xC; bus.v_yV = r_yC; bus.v_rV = r_rC;
            bus.v_xW = r_xA; bus.v_yW = r_yA; bus.v_rW = r_rA;
         end
         S_VE: begin
            bus.vtx_sel = 2'd1;
            bus.v_xU = r_xC; bus.v_yU = r_yC; bus.v_rU = r_rC;
            bus.v_xV = r_xA; bus.v_yV = r_yA; bus.v_rV = r_rA;
            bus.v_xW = r_xB; bus.v_yW = r_yB; bus.v_rW = r_rB;
         end
         S_VF: begin
            bus.vtx_sel = 2'd2;
            bus.v_xU = r_xA; bus.v_yU = r_yA; bus.v_rU = r_rA;
            bus.v_xV = r_xB; bus.v_yV = r_yB; bus.v_rV = r_rB;
            bus.v_xW = r_xC; bus.v_yW = r_yC; bus.v_rW = r_rC;
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state != S_IDLE);

   assign bus.m_xD = r_xD;
   assign bus.m_yD = r_yD;
   assign bus.m_xE = r_xE;
   assign bus.m_yE = r_yE;
   assign bus.m_xF = r_xF;
   assign bus.m_yF = r_yF;
   assign bus.xM   = r_xM;
   assign bus.yM   = r_yM;

endmodule
